// File: rtl/phase_tag_uart_tx.sv
// phase_tag_uart_tx
//   Drain side of the phase-tag FIFO. Pops one 16-bit tag per frame from the
//   FIFO read port and sends it as back-to-back 8N1 UART bytes:
//   SYNC_BYTE, tag[15:8], tag[7:0]. All logic runs on RdClk.
//   Optional feature macro: PHASE_TX_CHECKSUM_EN appends a fourth byte,
//   SYNC_BYTE ^ tag[15:8] ^ tag[7:0].
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (minimum 2)
//   SYNC_BYTE     first byte of every frame
// Ports
//   RdClk      in   clock, shared with the FIFO read port
//   rst_n      in   asynchronous active-low reset
//   enable     in   permits new pops (sampled only in IDLE)
//   Empty      in   FIFO empty flag (sampled only in IDLE)
//   data_out   in   FIFO Q, valid one cycle after RdEn
//   RdEn       out  FIFO read strobe, one cycle per tag
//   tx         out  UART line, idles high
//   busy       out  high in every state except IDLE
//   tag_count  out  frames fully transmitted, modulo 2^16
module phase_tag_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        RdClk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        Empty,
  input  logic [15:0] data_out,
  output logic        RdEn,
  output logic        tx,
  output logic        busy,
  output logic [15:0] tag_count
);

  localparam int unsigned       BAUD_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST     = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_LAST_DATA = 4'd8;
  localparam logic [3:0]        BIT_STOP      = 4'd9;
`ifdef PHASE_TX_CHECKSUM_EN
  localparam logic [1:0]        BYTE_LAST     = 2'd3;
`else
  localparam logic [1:0]        BYTE_LAST     = 2'd2;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       tag_q, tag_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  // bit index within a byte: 0 = start, 1..8 = data LSB first, 9 = stop
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic [15:0]       tag_count_q, tag_count_d;
  logic [7:0]        cur_byte_c;

  // Byte currently on the line, selected by frame position
  always_comb begin
    cur_byte_c = SYNC_BYTE;
    case (byte_idx_q)
      2'd1:    cur_byte_c = tag_q[15:8];
      2'd2:    cur_byte_c = tag_q[7:0];
`ifdef PHASE_TX_CHECKSUM_EN
      2'd3:    cur_byte_c = SYNC_BYTE ^ tag_q[15:8] ^ tag_q[7:0];
`endif
      default: cur_byte_c = SYNC_BYTE;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    baud_d      = baud_q;
    tx_d        = tx_q;
    rd_en_d     = 1'b0;
    busy_d      = 1'b0;
    tag_count_d = tag_count_q;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (enable && !Empty) begin
          state_d = POP;
          rd_en_d = 1'b1;
        end
      end

      POP: begin
        state_d = CAPTURE;
      end

      // FIFO Q is valid now; the start bit of byte 0 goes out next cycle
      CAPTURE: begin
        tag_d      = data_out;
        byte_idx_d = '0;
        bit_idx_d  = '0;
        baud_d     = '0;
        tx_d       = 1'b0;
        state_d    = SEND;
      end

      SEND: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_idx_q == BIT_STOP) begin
            bit_idx_d = '0;
            if (byte_idx_q == BYTE_LAST) begin
              state_d     = IDLE;
              tx_d        = 1'b1;
              tag_count_d = tag_count_q + 16'd1;
            end else begin
              // next byte's start bit follows the stop bit directly
              byte_idx_d = byte_idx_q + 2'd1;
              tx_d       = 1'b0;
            end
          end else begin
            // leaving bit n presents data bit n (or the stop bit after bit 8)
            bit_idx_d = bit_idx_q + 4'd1;
            tx_d      = (bit_idx_q == BIT_LAST_DATA) ? 1'b1 : cur_byte_c[bit_idx_q[2:0]];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge RdClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      byte_idx_q  <= '0;
      bit_idx_q   <= '0;
      baud_q      <= '0;
      tx_q        <= 1'b1;
      rd_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      tag_count_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      byte_idx_q  <= byte_idx_d;
      bit_idx_q   <= bit_idx_d;
      baud_q      <= baud_d;
      tx_q        <= tx_d;
      rd_en_q     <= rd_en_d;
      busy_q      <= busy_d;
      tag_count_q <= tag_count_d;
    end
  end

  assign RdEn      = rd_en_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign tag_count = tag_count_q;

endmodule
